btn_reset_ctrl: RTL and testbench
=================================

BTN_RESET_CTRL -- requirements
Module: btn_reset_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 65536: cycles of stable synchronised input required before the debounced level changes; must be >= 1.
REQ-002 Parameter HOLD_CYCLES, default 80000000 (1 s at 80 MHz): debounced-press duration that classifies a press as long; must be >= 1.
REQ-003 Parameter SOFT_RST_CYCLES, default 16: width of the soft-reset pulse in cycles; must be >= 1.
REQ-004 clk  input  1  system clock (clk_sys); all state SHALL be clocked on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_n  input  1  raw active-low button, asynchronous to clk and bouncing.
REQ-007 pressed  output  1  debounced button level; 1 = held.
REQ-008 soft_rst_req  output  1  active-high soft-reset pulse to the SoC core reset logic.
REQ-009 programn_n  output  1  active-low FPGA reconfiguration request, driven to user_programn.

Function
REQ-010 btn_n SHALL pass through a 2-flop synchroniser whose flops reset to 1 (released).
- REQ-011 Debounce counter:
  - Holds 0 while the synchronised level equals the debounced level.
  - Increments each cycle while they differ.
  - On reaching DEBOUNCE_CYCLES-1 while still differing, the debounced level SHALL toggle and the counter SHALL clear.
  - Any return to equality before that SHALL clear the counter.
REQ-012 pressed SHALL equal the inverted debounced level, registered; latency from a stable btn_n edge to pressed is 2 + DEBOUNCE_CYCLES cycles.
REQ-013 Counter widths SHALL be $clog2(max value + 1); counters SHALL saturate, never wrap.
- REQ-014 FSM states: IDLE, HELD, SOFT, RECONF, WAIT_REL.
- REQ-015 IDLE -> HELD on the cycle pressed rises; the hold counter clears to 0.
- REQ-016 HELD: the hold counter increments each cycle pressed is 1.
  - If pressed falls before the counter reaches HOLD_CYCLES-1: -> SOFT.
  - If the counter reaches HOLD_CYCLES-1 with pressed still 1: -> RECONF (macro defined) or WAIT_REL (macro undefined).
  - Release and hold-expiry in the same cycle SHALL be treated as long.
- REQ-017 SOFT: soft_rst_req SHALL be 1 for exactly SOFT_RST_CYCLES consecutive cycles, starting the cycle after entry; then -> IDLE.
  - A new press during SOFT SHALL be ignored until IDLE is reached.
  - A press still held at that point SHALL NOT retrigger; pressed must fall and rise again.
- REQ-018 WAIT_REL: all outputs are idle; -> SOFT when pressed falls.
- REQ-019 RECONF: programn_n SHALL be 0 from the cycle after entry and remain 0 regardless of button activity until rst.
REQ-020 soft_rst_req and programn_n SHALL be registered outputs, free of glitches, and never both active.

Reset
REQ-021 While rst is 1, the block SHALL hold these values, independent of clk:
  - FSM = IDLE, all counters = 0, synchroniser and debounced level = released.
  - pressed = 0, soft_rst_req = 0, programn_n = 1.
REQ-022 Reset asserted mid-pulse or in RECONF SHALL abort immediately with the values in REQ-021.
REQ-023 After rst deassertion, a button already held SHALL be seen as a new press, after the normal debounce latency.

Configuration
REQ-024 Macro BTN_RESET_CTRL_RECONFIG_EN:
  - Defined: a long press SHALL enter RECONF.
  - Undefined: programn_n SHALL be constant 1, no RECONF logic SHALL be synthesised, and a long press SHALL follow HELD -> WAIT_REL -> SOFT.

Verification
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, SOFT_RST_CYCLES=3.
REQ-025 Glitch: btn_n low 3 cycles, then high -> pressed stays 0, soft_rst_req stays 0, programn_n stays 1.
REQ-026 Short press: btn_n low 10 cycles, then high -> pressed rises 6 cycles after the low edge; soft_rst_req is high exactly 3 cycles after pressed falls; programn_n stays 1.
REQ-027 Long press, macro defined: btn_n low 40 cycles -> programn_n goes 0 21 cycles after pressed rises and stays 0 after release; soft_rst_req never asserts.
REQ-028 Long press, macro undefined: same stimulus -> programn_n stays 1; a single 3-cycle soft_rst_req pulse follows pressed falling.
REQ-029 Bounce: during HELD, btn_n high for 2 cycles -> pressed stays 1 and the FSM remains in HELD.
REQ-030 Reset mid-operation: rst asserted during the 2nd soft_rst_req cycle -> soft_rst_req = 0 and pressed = 0 asynchronously; no pulse resumes after rst releases with btn_n high.

Source files
------------

// File: rtl/btn_reset_ctrl_if.sv
// Signal bundle between the push-button front end and btn_reset_ctrl.
// master = the controller, slave = the board/environment side.
interface btn_reset_ctrl_if;
  logic btn_n;
  logic pressed;
  logic soft_rst_req;
  logic programn_n;

  modport master (input btn_n, output pressed, soft_rst_req, programn_n);
  modport slave  (output btn_n, input pressed, soft_rst_req, programn_n);
endinterface

// File: rtl/btn_reset_ctrl.sv
// Debounced push-button controller: a short press issues a soft-reset pulse, a long press requests reconfiguration.
// Define BTN_RESET_CTRL_RECONFIG_EN to let a long press pull programn_n low; otherwise a long press acts as a soft reset on release.
module btn_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int HOLD_CYCLES     = 80000000,
  parameter int SOFT_RST_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  btn_reset_ctrl_if.master bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int SW = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SOFT_LAST = SW'(SOFT_RST_CYCLES - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HELD = 3'd1;
  localparam logic [2:0] SOFT = 3'd2;
`ifdef BTN_RESET_CTRL_RECONFIG_EN
  localparam logic [2:0] RECONF     = 3'd4;
  localparam logic [2:0] LONG_STATE = RECONF;
`else
  localparam logic [2:0] WAIT_REL   = 3'd3;
  localparam logic [2:0] LONG_STATE = WAIT_REL;
`endif

  logic          sync1, sync2, deb_level, pressed_r, pressed_q, soft_r;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] soft_cnt;
  logic [2:0]    state, state_next;

  // Level changes only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      deb_level <= 1'b1;
      deb_cnt   <= '0;
      pressed_r <= 1'b0;
    end else begin
      sync1     <= bus.btn_n;
      sync2     <= sync1;
      pressed_r <= ~deb_level;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt >= DEB_LAST) begin
        deb_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pressed_r && !pressed_q) state_next = HELD;
      HELD: begin
        if (hold_cnt == HOLD_LAST)  state_next = LONG_STATE;
        else if (!pressed_r)        state_next = SOFT;
      end
      SOFT: if (soft_cnt == SOFT_LAST) state_next = IDLE;
`ifdef BTN_RESET_CTRL_RECONFIG_EN
      RECONF:   state_next = RECONF;
`else
      WAIT_REL: if (!pressed_r) state_next = SOFT;
`endif
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pressed_q <= 1'b0;
      hold_cnt  <= '0;
      soft_cnt  <= '0;
      soft_r    <= 1'b0;
    end else begin
      state     <= state_next;
      pressed_q <= pressed_r;
      soft_r    <= (state_next == SOFT);
      if (state == HELD && state_next == HELD) hold_cnt <= hold_cnt + HW'(1);
      else                                     hold_cnt <= '0;
      if (state == SOFT && state_next == SOFT) soft_cnt <= soft_cnt + SW'(1);
      else                                     soft_cnt <= '0;
    end
  end

`ifdef BTN_RESET_CTRL_RECONFIG_EN
  logic prog_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prog_r <= 1'b1;
    else     prog_r <= (state_next != RECONF);
  end

  assign bus.programn_n = prog_r;
`else
  assign bus.programn_n = 1'b1;
`endif

  assign bus.pressed      = pressed_r;
  assign bus.soft_rst_req = soft_r;

endmodule

// File: tb/tb_btn_reset_ctrl.sv
// Randomised and directed bench for btn_reset_ctrl against a timeline model of the button rules.
// Honours BTN_RESET_CTRL_RECONFIG_EN the same way as the design.
module tb_btn_reset_ctrl;
  localparam int D = 4;
  localparam int H = 20;
  localparam int S = 3;
`ifdef BTN_RESET_CTRL_RECONFIG_EN
  localparam bit RECONF_EN = 1'b1;
`else
  localparam bit RECONF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_reset_ctrl_if bus();

  btn_reset_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .SOFT_RST_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: raw samples per edge, sync window, and press timeline in absolute edge numbers.
  int   cyc;
  logic btn_hist[$];
  logic p_hist[$];
  logic samp[$];
  logic mdeb;
  bit   active, long_p;
  int   rise, soft_start, idle_from;

  int   n_press_hi, n_req, n_prog_lo, n_rises, rise_cyc, prog_fall_cyc;
  logic prev_pressed, prev_prog;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    if (observed != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic clearStats();
    n_press_hi    = 0;
    n_req         = 0;
    n_prog_lo     = 0;
    n_rises       = 0;
    rise_cyc      = -1;
    prog_fall_cyc = -1;
  endtask

  task automatic modelReset();
    cyc = 0;
    btn_hist.delete();
    btn_hist.push_back(1'b1);
    p_hist.delete();
    p_hist.push_back(1'b0);
    samp.delete();
    mdeb         = 1'b1;
    active       = 1'b0;
    long_p       = 1'b0;
    rise         = 0;
    soft_start   = -1;
    idle_from    = 0;
    prev_pressed = 1'b0;
    prev_prog    = 1'b1;
  endtask

  // Entered and left at a falling edge; rst is asserted there and checked asynchronously.
  task automatic doReset(input logic b);
    rst       = 1'b1;
    bus.btn_n = b;
    #1;
    checkOutput("rst_pressed", bus.pressed, 0);
    checkOutput("rst_soft", bus.soft_rst_req, 0);
    checkOutput("rst_programn", bus.programn_n, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input logic b);
    logic s, p_now, all_diff, pk1, pk2, exp_req, exp_prog;
    int   k;
    bus.btn_n = b;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc;
    btn_hist.push_back(b);
    s = (k >= 3) ? btn_hist[k-2] : 1'b1;
    samp.push_back(s);
    if (samp.size() > D) void'(samp.pop_front());
    p_now    = ~mdeb;
    all_diff = (samp.size() == D);
    foreach (samp[i]) if (samp[i] == mdeb) all_diff = 1'b0;
    if (all_diff) mdeb = ~mdeb;
    p_hist.push_back(p_now);
    pk1 = p_hist[k-1];
    pk2 = (k >= 2) ? p_hist[k-2] : 1'b0;

    if (soft_start >= 0 && k == soft_start + S) begin
      active     = 1'b0;
      soft_start = -1;
      idle_from  = k + 1;
    end
    if (!active) begin
      if (k >= idle_from && pk1 && !pk2) begin
        active = 1'b1;
        rise   = k - 1;
        long_p = 1'b0;
      end
    end else if (soft_start < 0) begin
      if (!long_p) begin
        if (k <= rise + H && !pk1)  soft_start = k;
        else if (k == rise + H + 1) long_p = 1'b1;
      end else if (!RECONF_EN && k >= rise + H + 2 && !pk1) begin
        soft_start = k;
      end
    end
    exp_req  = (soft_start >= 0) && (k >= soft_start) && (k < soft_start + S);
    exp_prog = !(RECONF_EN && long_p);

    checkOutput("pressed", bus.pressed, p_now);
    checkOutput("soft_rst_req", bus.soft_rst_req, exp_req);
    checkOutput("programn_n", bus.programn_n, exp_prog);

    if (bus.pressed) n_press_hi++;
    if (bus.soft_rst_req) n_req++;
    if (!bus.programn_n) n_prog_lo++;
    if (bus.pressed && !prev_pressed) begin
      n_rises++;
      if (rise_cyc < 0) rise_cyc = k;
    end
    if (!bus.programn_n && prev_prog && prog_fall_cyc < 0) prog_fall_cyc = k;
    prev_pressed = bus.pressed;
    prev_prog    = bus.programn_n;
    @(negedge clk);
  endtask

  initial begin
    int   start;
    int   len;
    logic lvl;
    bus.btn_n = 1'b1;
    @(negedge clk);
    doReset(1'b1);
    repeat (10) applyStimulus(1'b1);

    // Glitch shorter than the debounce window
    clearStats();
    repeat (3) applyStimulus(1'b0);
    repeat (20) applyStimulus(1'b1);
    checkOutput("glitch_pressed", n_press_hi, 0);
    checkOutput("glitch_soft", n_req, 0);
    checkOutput("glitch_prog", n_prog_lo, 0);

    // Short press
    clearStats();
    start = cyc + 1;
    repeat (10) applyStimulus(1'b0);
    repeat (30) applyStimulus(1'b1);
    checkOutput("short_rise_latency", rise_cyc - start, 6);
    checkOutput("short_soft_len", n_req, S);
    checkOutput("short_prog", n_prog_lo, 0);

    // Bounce while held
    clearStats();
    repeat (10) applyStimulus(1'b0);
    repeat (2) applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);
    repeat (30) applyStimulus(1'b1);
    checkOutput("bounce_rises", n_rises, 1);
    checkOutput("bounce_soft_len", n_req, S);

    // Long press
    clearStats();
    repeat (40) applyStimulus(1'b0);
    repeat (40) applyStimulus(1'b1);
    if (RECONF_EN) begin
      checkOutput("long_prog_delay", prog_fall_cyc - rise_cyc, H + 1);
      checkOutput("long_soft", n_req, 0);
      checkOutput("long_prog_held", bus.programn_n, 0);
    end else begin
      checkOutput("long_prog", n_prog_lo, 0);
      checkOutput("long_soft_len", n_req, S);
    end
    doReset(1'b1);

    // Reset during the second pulse cycle
    clearStats();
    repeat (10) applyStimulus(1'b0);
    for (int i = 0; i < 40 && n_req < 2; i++) applyStimulus(1'b1);
    checkOutput("midpulse_reach", n_req, 2);
    doReset(1'b1);
    clearStats();
    repeat (30) applyStimulus(1'b1);
    checkOutput("midpulse_no_resume", n_req, 0);

    // Button held through reset counts as a fresh press
    doReset(1'b0);
    clearStats();
    repeat (15) applyStimulus(1'b0);
    repeat (30) applyStimulus(1'b1);
    checkOutput("held_rst_rises", n_rises, 1);
    checkOutput("held_rst_soft_len", n_req, S);

    for (int r = 0; r < 12; r++) begin
      lvl = 1'($urandom_range(0, 1));
      doReset(lvl);
      for (int seg = 0; seg < 8; seg++) begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 45)) : int'($urandom_range(1, 12));
        for (int i = 0; i < len; i++) applyStimulus(lvl);
        lvl = ~lvl;
      end
      repeat (40) applyStimulus(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
